sub_magnitude_pipe: RTL

SUB_MAGNITUDE_PIPE -- requirements
Module: sub_magnitude_pipe

---
 rtl/sub_mag_pkg.sv | 34 +++
 rtl/sub_borrow_stage.sv | 35 +++
 rtl/sub_magnitude_pipe.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sub_mag_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sub_mag_pkg
// Purpose : Shared definitions for sub_magnitude_pipe. Holds the sample mode
//           encodings, the accumulator FSM state type and a clog2 helper.
// Ports   : (package, none)
// Rev     : 1.0  initial release
// ============================================================================
package sub_mag_pkg;

  localparam logic MODE_SAMPLE = 1'b0;
  localparam logic MODE_ACCUM  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } acc_state_t;

  // Ceiling log2. This is used to size the result and the group counter.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sub_borrow_stage.sv
`default_nettype none
// ============================================================================
// Module  : sub_borrow_stage
// Purpose : Combinational ripple subtractor. It computes D = A - B
//           (mod 2^WIDTH) and the borrow out of the MSB, which is set when A < B.
// Ports   : i_a      [WIDTH] minuend
//           i_b      [WIDTH] subtrahend
//           o_d      [WIDTH] difference mod 2^WIDTH
//           o_borrow [1]     borrow out (A < B)
// Rev     : 1.0  initial release
// ============================================================================
module sub_borrow_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_d,
  output logic             o_borrow
);

  // The borrow ripples through a local variable. A self-referencing chain
  // vector would create an apparent combinational loop.
  always_comb begin
    logic v_bw;
    v_bw = 1'b0;
    o_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_d[i] = i_a[i] ^ i_b[i] ^ v_bw;
      v_bw   = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & v_bw);
    end
    o_borrow = v_bw;
  end

endmodule
`default_nettype wire

// File: rtl/sub_magnitude_pipe.sv
`default_nettype none
// ============================================================================
// Module  : sub_magnitude_pipe
// Purpose : Two-stage |A-B| pipeline with valid/ready handshakes.
//           - Stage 1 registers the difference and the borrow.
//           - Stage 2 either emits each magnitude (mode 0) or sums ACC_LEN
//             magnitudes into one group result (mode 1).
// Ports   : clk, rst            clock, async active-high reset
//           in_valid/in_ready   input handshake
//           in_a, in_b [WIDTH]  unsigned operands
//           in_mode             0 = per sample, 1 = accumulate group
//           out_valid/out_ready output handshake
//           out_mag [ACC_WIDTH] magnitude or group sum
//           out_b               borrow (OR of the borrows over a group)
//           out_last            closing result flag
// Rev     : 1.0  initial release
// ============================================================================
module sub_magnitude_pipe
  import sub_mag_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_LEN   = 16,
  parameter int ACC_WIDTH = WIDTH + clog2(ACC_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_mag,
  output logic                 out_b,
  output logic                 out_last
);

  localparam int C_CNT_W = clog2(ACC_LEN);

  // Stage 1 signals
  logic [WIDTH-1:0] w_d;
  logic             w_borrow;
  logic             r_live;
  logic             r_s1_full;
  logic [WIDTH-1:0] r_s1_d;
  logic             r_s1_b;
  logic             r_s1_mode;

  // Stage 2 / FSM signals
  acc_state_t           r_state, w_state_nxt;
  logic [ACC_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [C_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic                 r_bflag, w_bflag_nxt;
  logic [WIDTH-1:0]     w_mag;
  logic [ACC_WIDTH-1:0] w_mag_ext;
  logic                 w_s2_free;
  logic                 w_s2_take;

  sub_borrow_stage #(.WIDTH(WIDTH)) u_borrow_stage (
    .i_a      (in_a),
    .i_b      (in_b),
    .o_d      (w_d),
    .o_borrow (w_borrow)
  );

  // Stage 2 is free unless a result is sitting in EMIT without being taken.
  assign w_s2_free = (r_state != ST_EMIT) || out_ready;
  assign w_s2_take = r_s1_full && w_s2_free;
  // r_live keeps in_ready low during reset and for the cycle that ends it.
  assign in_ready  = r_live && (!r_s1_full || w_s2_take);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live    <= 1'b0;
      r_s1_full <= 1'b0;
      r_s1_d    <= '0;
      r_s1_b    <= 1'b0;
      r_s1_mode <= MODE_SAMPLE;
    end else begin
      r_live <= 1'b1;
      if (in_ready) begin
        r_s1_full <= in_valid;
        if (in_valid) begin
          r_s1_d    <= w_d;
          r_s1_b    <= w_borrow;
          r_s1_mode <= in_mode;
        end
      end
    end
  end

  // Two's-complement negation of a borrowed difference gives the exact |A-B|.
  assign w_mag     = r_s1_b ? (~r_s1_d + WIDTH'(1)) : r_s1_d;
  assign w_mag_ext = ACC_WIDTH'(w_mag);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_bflag_nxt = r_bflag;

    if ((r_state == ST_EMIT) && out_ready) begin
      w_state_nxt = ST_IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_bflag_nxt = 1'b0;
    end

    if (w_s2_take) begin
      if (r_state == ST_ACCUM) begin
        // The group mode is fixed, so the sample's own mode is ignored here.
        w_acc_nxt   = r_acc + w_mag_ext;
        w_bflag_nxt = r_bflag | r_s1_b;
        if (r_cnt == C_CNT_W'(ACC_LEN - 1)) begin
          w_state_nxt = ST_EMIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_W'(1);
        end
      end else begin
        // Either IDLE, or EMIT whose result leaves this cycle. In both cases
        // this sample opens a new group or a new single result.
        w_acc_nxt   = w_mag_ext;
        w_bflag_nxt = r_s1_b;
        if (r_s1_mode == MODE_SAMPLE) begin
          w_state_nxt = ST_EMIT;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_ACCUM;
          w_cnt_nxt   = C_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_bflag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bflag <= w_bflag_nxt;
    end
  end

  assign out_valid = (r_state == ST_EMIT);
  assign out_mag   = r_acc;
  assign out_b     = r_bflag;
  assign out_last  = out_valid;

endmodule
`default_nettype wire
